// File: rtl/breath_pkg.sv
// Shared types and constants for the LED breathing sequencer.
package breath_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RAMP_UP,
    HOLD_HI,
    RAMP_DN,
    HOLD_LO
  } state_t;

  localparam logic [1:0] MODE_ALL   = 2'b00;
  localparam logic [1:0] MODE_CHASE = 2'b01;
  localparam logic [1:0] MODE_ALT   = 2'b10;
  localparam logic [1:0] MODE_OFF   = 2'b11;

  localparam logic [7:0] DUTY_MAX = 8'd255;

endpackage

// File: rtl/breath_step_timer.sv
// Duty step timer: counts 0..STEP_CYCLES-1, ticks on the terminal count, held at 0 by clear.
module breath_step_timer #(
  parameter int unsigned STEP_CYCLES = 31250
) (
  input  logic clk,
  input  logic reset_,
  input  logic clear,
  output logic step_tick
);

  localparam int unsigned CW = $clog2(STEP_CYCLES);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last    = (r_cnt == CW'(STEP_CYCLES - 1));
  assign step_tick = w_last && !clear;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_cnt <= '0;
    end else if (clear || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/breath_sequencer.sv
// Breathing-brightness sequencer for the 8-bit LED bank (triangle duty + PWM).
// Optional BREATH_GAMMA_EN: squared duty compare via a pipeline register (+1 clock led latency).
module breath_sequencer
  import breath_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 31250,
  parameter int unsigned HOLD_STEPS  = 64
) (
  input  logic       clk,
  input  logic       reset_,
  input  logic       enable,
  input  logic [1:0] mode,
  output logic [7:0] led,
  output logic       busy,
  output logic       cycle_done
);

  localparam int unsigned HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

  state_t        r_state, w_next;
  logic [7:0]    r_duty, w_duty_nx;
  logic [7:0]    r_pwm;
  logic [HW-1:0] r_hold, w_hold_nx;
  logic [2:0]    r_idx, w_idx_nx;
  logic [1:0]    r_mode_q, w_mode_nx;
  logic          w_cd_nx;
  logic [7:0]    r_led, w_led_nx;
  logic          r_busy, r_cd;
  logic          w_tick, w_hold_last;
  logic [7:0]    w_duty_inv, w_cmp, w_cmp_inv;
  logic          w_on, w_on_inv;

  breath_step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_timer (
    .clk      (clk),
    .reset_   (reset_),
    .clear    (r_state == IDLE),
    .step_tick(w_tick)
  );

  assign w_hold_last = (r_hold == HW'(HOLD_STEPS - 1));
  assign w_duty_inv  = DUTY_MAX - r_duty;

`ifdef BREATH_GAMMA_EN
  logic [15:0] w_sq, w_sq_inv;
  logic [7:0]  r_gamma, r_gamma_inv;
  assign w_sq     = 16'(r_duty) * 16'(r_duty);
  assign w_sq_inv = 16'(w_duty_inv) * 16'(w_duty_inv);
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_gamma     <= '0;
      r_gamma_inv <= '0;
    end else begin
      r_gamma     <= w_sq[15:8];
      r_gamma_inv <= w_sq_inv[15:8];
    end
  end
  assign w_cmp     = r_gamma;
  assign w_cmp_inv = r_gamma_inv;
`else
  assign w_cmp     = r_duty;
  assign w_cmp_inv = w_duty_inv;
`endif

  assign w_on     = (r_pwm < w_cmp);
  assign w_on_inv = (r_pwm < w_cmp_inv);

  // Stop requests (enable low) take priority over a coincident step tick.
  always_comb begin
    w_next    = r_state;
    w_duty_nx = r_duty;
    w_hold_nx = r_hold;
    w_idx_nx  = r_idx;
    w_mode_nx = r_mode_q;
    w_cd_nx   = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable) begin
          w_next    = RAMP_UP;
          w_mode_nx = mode;
        end
      end
      RAMP_UP: begin
        if (!enable) begin
          w_next = RAMP_DN;
        end else if (w_tick) begin
          w_duty_nx = r_duty + 8'd1;
          if (r_duty == DUTY_MAX - 8'd1) begin
            w_next    = HOLD_HI;
            w_hold_nx = '0;
          end
        end
      end
      HOLD_HI: begin
        if (!enable) begin
          w_next = RAMP_DN;
        end else if (w_tick) begin
          if (w_hold_last) w_next = RAMP_DN;
          else             w_hold_nx = r_hold + 1'b1;
        end
      end
      RAMP_DN: begin
        if (w_tick) begin
          // A stop right out of IDLE can reach here at duty 0; clamp instead of wrapping.
          if (r_duty <= 8'd1) begin
            w_duty_nx = '0;
            w_hold_nx = '0;
            w_next    = enable ? HOLD_LO : IDLE;
          end else begin
            w_duty_nx = r_duty - 8'd1;
          end
        end
      end
      HOLD_LO: begin
        if (!enable) begin
          w_next = IDLE;
        end else if (w_tick) begin
          if (w_hold_last) begin
            w_next    = RAMP_UP;
            w_cd_nx   = 1'b1;
            w_mode_nx = mode;
            if (r_mode_q == MODE_CHASE) w_idx_nx = r_idx + 3'd1;
          end else begin
            w_hold_nx = r_hold + 1'b1;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_led_nx = '0;
    if (r_state != IDLE) begin
      case (r_mode_q)
        MODE_ALL:   w_led_nx = {8{w_on}};
        MODE_CHASE: w_led_nx[r_idx] = w_on;
        MODE_ALT:   w_led_nx = {4{w_on_inv, w_on}};
        default:    w_led_nx = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state  <= IDLE;
      r_duty   <= '0;
      r_pwm    <= '0;
      r_hold   <= '0;
      r_idx    <= '0;
      r_mode_q <= MODE_ALL;
      r_led    <= '0;
      r_busy   <= 1'b0;
      r_cd     <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_duty   <= w_duty_nx;
      r_pwm    <= r_pwm + 8'd1;
      r_hold   <= w_hold_nx;
      r_idx    <= w_idx_nx;
      r_mode_q <= w_mode_nx;
      r_led    <= w_led_nx;
      r_busy   <= (r_state != IDLE);
      r_cd     <= w_cd_nx;
    end
  end

  assign led        = r_led;
  assign busy       = r_busy;
  assign cycle_done = r_cd;

endmodule

// File: tb/tb_breath_sequencer.sv
// Self-checking bench for breath_sequencer: cycle scoreboard plus table rows and corner sequences.
module tb_breath_sequencer;
  import breath_pkg::*;

  localparam int STEP = 4;
  localparam int HOLD = 2;

  logic       clk = 1'b0;
  logic       reset_ = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] led;
  logic       busy;
  logic       cycle_done;

  int checks = 0;
  int failures = 0;

  breath_sequencer #(.STEP_CYCLES(STEP), .HOLD_STEPS(HOLD)) dut (
    .clk       (clk),
    .reset_    (reset_),
    .enable    (enable),
    .mode      (mode),
    .led       (led),
    .busy      (busy),
    .cycle_done(cycle_done)
  );

  always #15 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference model of the sequencer, stepped on each clock edge.
  typedef struct {
    logic [7:0] led;
    logic       busy;
    logic       cd;
  } exp_t;

  exp_t   sb_q[$];
  state_t m_state = IDLE;
  int     m_duty = 0;
  int     m_pwm = 0;
  int     m_step = 0;
  int     m_hold = 0;
  int     m_idx = 0;
  int     m_modeq = 0;

  initial forever begin
    @(posedge clk or negedge reset_);
    if (!reset_) begin
      m_state = IDLE; m_duty = 0; m_pwm = 0; m_step = 0;
      m_hold = 0; m_idx = 0; m_modeq = 0;
      sb_q.delete();
      sb_q.push_back('{led: 8'h00, busy: 1'b0, cd: 1'b0});
    end else begin
      exp_t e;
      logic tick, on, on_inv;
      tick   = (m_state != IDLE) && (m_step == STEP - 1);
      on     = (m_pwm < m_duty);
      on_inv = (m_pwm < 255 - m_duty);
      e.led  = 8'h00;
      if (m_state != IDLE) begin
        case (m_modeq)
          0: e.led = on ? 8'hFF : 8'h00;
          1: e.led[m_idx] = on;
          2: e.led = (on ? 8'h55 : 8'h00) | (on_inv ? 8'hAA : 8'h00);
          default: e.led = 8'h00;
        endcase
      end
      e.busy = (m_state != IDLE);
      e.cd   = 1'b0;
      m_step = (m_state == IDLE || tick) ? 0 : m_step + 1;
      m_pwm  = (m_pwm + 1) % 256;
      case (m_state)
        IDLE: if (enable) begin m_state = RAMP_UP; m_modeq = int'(mode); end
        RAMP_UP:
          if (!enable) m_state = RAMP_DN;
          else if (tick) begin
            m_duty++;
            if (m_duty == 255) begin m_state = HOLD_HI; m_hold = 0; end
          end
        HOLD_HI:
          if (!enable) m_state = RAMP_DN;
          else if (tick) begin
            m_hold++;
            if (m_hold == HOLD) m_state = RAMP_DN;
          end
        RAMP_DN:
          if (tick) begin
            if (m_duty > 0) m_duty--;
            if (m_duty == 0) begin
              if (enable) begin m_state = HOLD_LO; m_hold = 0; end
              else m_state = IDLE;
            end
          end
        HOLD_LO:
          if (!enable) m_state = IDLE;
          else if (tick) begin
            m_hold++;
            if (m_hold == HOLD) begin
              e.cd = 1'b1;
              if (m_modeq == 1) m_idx = (m_idx + 1) % 8;
              m_modeq = int'(mode);
              m_state = RAMP_UP;
            end
          end
        default: m_state = IDLE;
      endcase
      sb_q.push_back(e);
    end
  end

  initial forever begin
    @(negedge clk);
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check("sb_led_busy_cd", {led, busy, cycle_done}, {e.led, e.busy, e.cd});
    end
  end

  typedef struct {
    logic       en;
    logic [1:0] md;
    int         cycles;
    logic       exp_busy;
    int         exp_pulses;
    logic [7:0] exp_led_or;
  } row_t;

  task automatic wait_cd(input string name, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cycle_done && n < 3000);
    check(name, cycle_done, 1'b1);
  endtask

  initial begin
    row_t rows[3];
    int   n;
    rows[0] = '{en: 1'b0, md: 2'b00, cycles: 50,   exp_busy: 1'b0, exp_pulses: 0, exp_led_or: 8'h00};
    rows[1] = '{en: 1'b1, md: 2'b00, cycles: 2057, exp_busy: 1'b1, exp_pulses: 1, exp_led_or: 8'hFF};
    rows[2] = '{en: 1'b1, md: 2'b00, cycles: 2056, exp_busy: 1'b1, exp_pulses: 1, exp_led_or: 8'hFF};

    #100 reset_ = 1'b1;
    @(negedge clk);
    check("reset_led", led, 8'h00);
    check("reset_busy", busy, 1'b0);
    check("reset_cd", cycle_done, 1'b0);

    // Idle hold, then two full in-phase cycles of 2056 clocks each.
    for (int unsigned r = 0; r < 3; r++) begin
      int         pulses;
      logic [7:0] acc;
      pulses = 0;
      acc    = 8'h00;
      enable = rows[r].en;
      mode   = rows[r].md;
      for (int k = 0; k < rows[r].cycles; k++) begin
        @(negedge clk);
        if (cycle_done) pulses++;
        acc |= led;
      end
      check($sformatf("row%0d_busy", r), busy, rows[r].exp_busy);
      check($sformatf("row%0d_pulses", r), pulses, rows[r].exp_pulses);
      check($sformatf("row%0d_led_or", r), acc, rows[r].exp_led_or);
    end

    // Chase: lit bit walks 0..7 and wraps over 9 cycles.
    mode = 2'b01;
    wait_cd("chase_enter", n);
    for (int unsigned c = 0; c < 9; c++) begin
      logic [7:0] acc;
      logic [7:0] exp8;
      acc  = 8'h00;
      exp8 = 8'h01 << (c % 8);
      n = 0;
      do begin
        @(negedge clk);
        n++;
        acc |= led;
        check("chase_onehot", ($countones(led) <= 1), 1'b1);
      end while (!cycle_done && n < 3000);
      check("chase_cd", cycle_done, 1'b1);
      check($sformatf("chase_bit_c%0d", c), acc, exp8);
    end

    // Antiphase: even and odd groups each uniform, and the two groups differ at times.
    mode = 2'b10;
    wait_cd("alt_enter", n);
    mode = 2'b00;
    begin
      int diff;
      diff = 0;
      n = 0;
      do begin
        @(negedge clk);
        n++;
        check("alt_even_uniform", ((led & 8'h55) == 8'h00) || ((led & 8'h55) == 8'h55), 1'b1);
        check("alt_odd_uniform", ((led & 8'hAA) == 8'h00) || ((led & 8'hAA) == 8'hAA), 1'b1);
        if (led[0] != led[1]) diff++;
      end while (!cycle_done && n < 3000);
      check("alt_cd", cycle_done, 1'b1);
      check("alt_groups_differ", (diff > 0), 1'b1);
    end

    // Graceful stop in RAMP_UP at duty 100: 100 ticks down, busy falls 401 clocks later, no pulse.
    n = 0;
    while (!(m_state == RAMP_UP && m_duty == 100) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("stop_reach_duty100", (m_duty == 100), 1'b1);
    enable = 1'b0;
    begin
      int pulses;
      pulses = 0;
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (cycle_done) pulses++;
      end while (busy && n < 1000);
      check("stop_busy_fall_clocks", n, 401);
      check("stop_no_pulse", pulses, 0);
    end

    // Async reset during HOLD_HI, then restart from duty 0.
    enable = 1'b1;
    n = 0;
    while (m_state != HOLD_HI && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("reach_hold_hi", (m_state == HOLD_HI), 1'b1);
    @(posedge clk);
    #3 reset_ = 1'b0;
    #1;
    check("async_rst_led", led, 8'h00);
    check("async_rst_busy", busy, 1'b0);
    #9 reset_ = 1'b1;
    @(posedge clk);
    wait_cd("restart_cd", n);
    check("restart_cycle_clocks", n, 2057);

    enable = 1'b0;
    n = 0;
    while (busy && n < 1200) begin
      @(negedge clk);
      n++;
    end
    check("final_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
